// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree walker: node-word layout,
// controller states and the decoded node header.
package dtree_pkg;

    localparam int FEAT_W  = 8;
    localparam int FSEL_W  = 3;
    localparam int SHIFT_W = 3;
    localparam int THR_W   = 8;
    localparam int HDR_W   = 1 + FSEL_W + SHIFT_W + THR_W;

    // Node word, MSB first: leaf, fsel, shift, thr, left, right.
    function automatic int node_w(input int addr_w);
        return HDR_W + 2 * addr_w;
    endfunction

    function automatic int right_lsb(input int addr_w);
        return 0 * addr_w;
    endfunction

    function automatic int left_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int thr_lsb(input int addr_w);
        return 2 * addr_w;
    endfunction

    function automatic int shift_lsb(input int addr_w);
        return 2 * addr_w + THR_W;
    endfunction

    function automatic int fsel_lsb(input int addr_w);
        return 2 * addr_w + THR_W + SHIFT_W;
    endfunction

    function automatic int leaf_bit(input int addr_w);
        return 2 * addr_w + THR_W + SHIFT_W + FSEL_W;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic               leaf;
        logic [FSEL_W-1:0]  fsel;
        logic [SHIFT_W-1:0] shift;
        logic [THR_W-1:0]   thr;
    } node_hdr_t;

endpackage

// File: rtl/dtree_node_cmp.sv
// Shared node comparator: picks one feature, shifts it right and tests it
// against the node threshold (unsigned).
module dtree_node_cmp
    import dtree_pkg::*;
#(
    parameter int N_FEAT = 5
) (
    input  logic [FEAT_W*N_FEAT-1:0] feat,
    input  logic [FSEL_W-1:0]        fsel,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic [THR_W-1:0]         thr,
    output logic                     cond
);

    logic [FEAT_W-1:0] sel;

    // Out-of-range selectors fall back to feature 0.
    always_comb begin
        sel = feat[FEAT_W-1:0];
        for (int i = 1; i < N_FEAT; i++) begin
            if (fsel == FSEL_W'(i)) sel = feat[i*FEAT_W +: FEAT_W];
        end
    end

    assign cond = (sel >> shift) <= thr;

endmodule

// File: rtl/dtree_walk_ctrl.sv
// Decision-tree walker: fetches one node per two cycles from an external
// synchronous table and resolves it through a single shared comparator.
module dtree_walk_ctrl
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = 5,
    parameter int ADDR_W    = 6,
    parameter int CLASS_W   = 5,
    parameter int MAX_DEPTH = 15,
    localparam int NODE_W   = 15 + 2 * ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*N_FEAT-1:0]     in_feat,
    output logic [ADDR_W-1:0]       node_addr,
    output logic                    node_rd,
    input  logic [NODE_W-1:0]       node_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLASS_W-1:0]      out_class,
    output logic                    out_err,
    output logic [3:0]              out_depth
);

    localparam int LEFT_LSB  = left_lsb(ADDR_W);
    localparam int RIGHT_LSB = right_lsb(ADDR_W);
    localparam int HDR_LSB   = thr_lsb(ADDR_W);

    state_e                 state_q, state_d;
    logic [8*N_FEAT-1:0]    feat_q, feat_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rd_q, rd_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [CLASS_W-1:0]     class_q, class_d;
    logic                   err_q, err_d;
    logic [3:0]             depth_q, depth_d;

    node_hdr_t              hdr;
    logic [ADDR_W-1:0]      left, right;
    logic                   cond;

    assign hdr   = node_hdr_t'(node_data[HDR_LSB +: HDR_W]);
    assign left  = node_data[LEFT_LSB +: ADDR_W];
    assign right = node_data[RIGHT_LSB +: ADDR_W];

    dtree_node_cmp #(.N_FEAT(N_FEAT)) u_cmp (
        .feat  (feat_q),
        .fsel  (hdr.fsel),
        .shift (hdr.shift),
        .thr   (hdr.thr),
        .cond  (cond)
    );

    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        addr_d      = addr_q;
        rd_d        = 1'b0;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        class_d     = class_q;
        err_d       = err_q;
        depth_d     = depth_q;
        unique case (state_q)
            S_IDLE: if (in_valid) begin
                feat_d     = in_feat;
                depth_d    = '0;
                addr_d     = '0;
                rd_d       = 1'b1;
                in_ready_d = 1'b0;
                state_d    = S_FETCH;
            end
            S_FETCH: state_d = S_EVAL;
            S_EVAL: begin
                if (hdr.leaf) begin
                    class_d     = hdr.thr[CLASS_W-1:0];
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (depth_q == 4'(MAX_DEPTH)) begin
                    class_d     = '0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    depth_d = depth_q + 4'd1;
                    addr_d  = cond ? left : right;
                    rd_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            feat_q      <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            class_q     <= '0;
            err_q       <= 1'b0;
            depth_q     <= '0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            class_q     <= class_d;
            err_q       <= err_d;
            depth_q     <= depth_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign node_addr = addr_q;
    assign node_rd   = rd_q;
    assign out_valid = out_valid_q;
    assign out_class = class_q;
    assign out_err   = err_q;
    assign out_depth = depth_q;

endmodule

// File: doc/dtree_walk_ctrl.md
Name: dtree_walk_ctrl

Overview:
- Sequential decision-tree evaluator: walks a node table held in external synchronous ROM/RAM, one node per 2 cycles, through a single shared prefix comparator.
- Replaces a flat combinational tree of prefix compares when area matters more than latency. Sits between the feature-sampling front end and the class consumer.
- Accepts one 5-feature sample over valid/ready and returns the class over valid/ready, with an error flag for runaway walks.

Parameters:
- N_FEAT, 5, number of 8-bit input features
- ADDR_W, 6, node-table address width
- CLASS_W, 5, class output width
- MAX_DEPTH, 15, maximum internal nodes visited before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  controller idle, sample accepted when in_valid&in_ready
- in_feat  in  8*N_FEAT  features, feature i at [8i+7:8i]
- node_addr  out  ADDR_W  node-table read address
- node_rd  out  1  read strobe
- node_data  in  NODE_W  node word, valid the cycle after node_rd
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  predicted class
- out_err  out  1  depth limit hit; out_class=0 in that case
- out_depth  out  4  internal nodes visited

Behaviour:
- Node word is NODE_W = 1+3+3+8+2*ADDR_W bits, MSB first: leaf, fsel[2:0], shift[2:0], thr[7:0], left[ADDR_W-1:0], right[ADDR_W-1:0].
- Internal node: cond = (feat[fsel] >> shift) <= thr, unsigned, 8-bit compare. cond=1 goes to left, else right.
- Leaf node: class = thr[CLASS_W-1:0]; fsel, shift and children are ignored.
- fsel >= N_FEAT is treated as feature 0.
- Root is address 0.
- States are IDLE, FETCH, EVAL, DONE.
- IDLE: in_ready=1. On accept, latch all features, clear depth, set node_addr=0, go to FETCH.
- FETCH: node_rd=1 for exactly one cycle, go to EVAL.
- EVAL: node_data is sampled this cycle.
  - Leaf: latch class, err=0, go to DONE.
  - Internal node with depth==MAX_DEPTH: err=1, class=0, go to DONE.
  - Otherwise: depth++, node_addr = chosen child, go to FETCH.
- DONE: out_valid=1 and outputs held stable until out_ready. On out_valid&out_ready go to IDLE. in_ready stays 0 until the IDLE cycle, so there is no same-cycle re-accept.
- Latency from accept to out_valid = 2*(d+1)+1 cycles, where d = internal nodes visited. A root leaf gives 3 cycles.
- Latched features are unaffected by in_feat changes after accept.
- Self-loops and cycles in the table are caught by MAX_DEPTH.
- Reset, at any time including mid-walk or while DONE is stalled:
  - State returns to IDLE.
  - in_ready=1 after deassertion.
  - node_rd=0, node_addr=0, out_valid=0, out_class=0, out_err=0, out_depth=0.
  - The node-read in flight is discarded.
- node_rd is asserted only in FETCH.
- in_ready and out_valid are never high together.

Decomposition:
- Shared package dtree_pkg holds:
  - field offsets and widths for the node word, and the NODE_W function of ADDR_W
  - a state enum
  - a node struct typedef
- One sub-module, dtree_node_cmp: combinational feature mux + shift + compare. Inputs are the feature vector, fsel, shift, thr; output is cond. It is the single shared comparator.

Test Plan:
- Root leaf: node0 = leaf, thr=17. Any sample -> out_valid 3 cycles after accept, out_class=17, out_depth=0, out_err=0.
- Two-level walk:
  - node0 = (fsel 4, shift 6, thr 0, left 1, right 2); node1 = leaf 7; node2 = (fsel 0, shift 5, thr 1, left 3, right 4); node3 = leaf 11; node4 = leaf 12.
  - Feat4=0x20 -> class 7, depth 1, latency 5.
  - Feat4=0xC0, feat0=0x3F -> class 11, depth 2, latency 7.
  - Feat4=0xC0, feat0=0xE0 -> class 12.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, class and depth stable; in_ready=0 throughout; in_valid pulses ignored. Releasing out_ready -> in_ready=1 the next cycle.
- Runaway: node0 internal with left=right=0 -> after MAX_DEPTH=15 internal visits, out_err=1, out_class=0, out_depth=15.
- Reset mid-walk: assert rst_n=0 during EVAL of depth 1 -> immediately in_ready=1 after release, node_rd=0, out_valid=0. A new sample evaluates correctly from root.
- Feature latching: change in_feat the cycle after accept -> result matches the originally accepted sample.
